// File: rtl/intr_pkg.sv
// -----------------------------------------------------------------------------
// intr_pkg
// Shared definitions for the interrupt controller slice:
//   - default source count and cause-index width
//   - handshake state enumeration used by the controller FSM
// -----------------------------------------------------------------------------
package intr_pkg;

   // Default geometry: four peripheral lines, two-bit cause index.
   localparam int unsigned N_SRC_DEF   = 4;
   localparam int unsigned CAUSE_W_DEF = 2;

   // Handshake with the CPU:
   //   ST_IDLE    - nothing presented, waiting for an enabled pending source
   //   ST_REQ     - Intr asserted, waiting for Inta
   //   ST_SERVICE - handler running, waiting for Eoi
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } intr_state_e;

endpackage : intr_pkg

// File: rtl/intr_prio_enc.sv
// -----------------------------------------------------------------------------
// intr_prio_enc
// Combinational fixed-priority encoder: the lowest set index of req wins.
//
// Ports:
//   req   in  [N_SRC-1:0]   request vector (already masked by the caller)
//   idx   out [CAUSE_W-1:0] index of the winning request (0 when none)
//   valid out 1             at least one request bit is set
// -----------------------------------------------------------------------------
module intr_prio_enc
   import intr_pkg::*;
#(
   parameter int unsigned N_SRC   = N_SRC_DEF,
   parameter int unsigned CAUSE_W = CAUSE_W_DEF
) (
   input  logic [N_SRC-1:0]   req,
   output logic [CAUSE_W-1:0] idx,
   output logic               valid
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment, otherwise synthesis infers a latch.
      idx   = '0;
      valid = |req;
      // Scan from the top down so the lowest set index is the last write.
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = CAUSE_W'(i);
         end
      end
   end

endmodule : intr_prio_enc

// File: rtl/intr_controller.sv
// -----------------------------------------------------------------------------
// intr_controller
// Edge-triggered, maskable, fixed-priority interrupt controller that drives the
// CPU's Intr/Inta handshake and waits for end-of-interrupt before presenting
// the next request. No nesting: arrivals during a handshake only accumulate in
// Pending.
//
// Ports:
//   Clk        in  1         rising-edge clock
//   Reset      in  1         synchronous, active-high reset
//   Irq        in  N_SRC     peripheral request lines (rising edge posts)
//   MaskWe     in  1         enable-mask write strobe
//   MaskWdata  in  N_SRC     new enable mask (1 = enabled)
//   Inta       in  1         CPU acknowledge pulse (honoured only in REQ)
//   Eoi        in  1         end-of-interrupt pulse (honoured only in SERVICE)
//   Intr       out 1         registered interrupt request to the CPU
//   Cause      out CAUSE_W   registered index of requested/in-service source
//   Pending    out N_SRC     posted, not yet acknowledged requests
//   Mask       out N_SRC     current enable mask
// -----------------------------------------------------------------------------
module intr_controller
   import intr_pkg::*;
#(
   parameter int unsigned N_SRC   = N_SRC_DEF,
   parameter int unsigned CAUSE_W = CAUSE_W_DEF  // must equal clog2(N_SRC)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [N_SRC-1:0]   Irq,
   input  logic               MaskWe,
   input  logic [N_SRC-1:0]   MaskWdata,
   input  logic               Inta,
   input  logic               Eoi,
   output logic               Intr,
   output logic [CAUSE_W-1:0] Cause,
   output logic [N_SRC-1:0]   Pending,
   output logic [N_SRC-1:0]   Mask
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   intr_state_e        state_q,   state_d;
   logic [N_SRC-1:0]   history_q, history_d;
   logic [N_SRC-1:0]   pending_q, pending_d;
   logic [N_SRC-1:0]   mask_q,    mask_d;
   logic               intr_q,    intr_d;
   logic [CAUSE_W-1:0] cause_q,   cause_d;

   // ---------------------------------------------------------------------------
   // Edge detect
   // History resets to zero, so a line already high when reset releases is
   // seen as a rise on the first cycle; a line held high rises only once.
   // ---------------------------------------------------------------------------
   logic [N_SRC-1:0] rise;

   always_comb begin
      history_d = Irq;
      rise      = Irq & ~history_q;
   end

   // ---------------------------------------------------------------------------
   // Arbitration over enabled pending sources
   // ---------------------------------------------------------------------------
   logic [N_SRC-1:0]   enabled_req;
   logic [CAUSE_W-1:0] win_idx;
   logic               win_valid;

   assign enabled_req = pending_q & mask_q;

   intr_prio_enc #(
      .N_SRC   (N_SRC),
      .CAUSE_W (CAUSE_W)
   ) u_prio_enc (
      .req   (enabled_req),
      .idx   (win_idx),
      .valid (win_valid)
   );

   // ---------------------------------------------------------------------------
   // Handshake FSM, next-state and registered outputs
   // ---------------------------------------------------------------------------
   logic ack;  // Inta accepted this cycle

   always_comb begin
      state_d = state_q;
      intr_d  = intr_q;
      cause_d = cause_q;
      ack     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            intr_d = 1'b0;
            if (win_valid) begin
               // Cause is captured once here and frozen for the whole
               // handshake; later arrivals or mask writes cannot retarget it.
               cause_d = win_idx;
               intr_d  = 1'b1;
               state_d = ST_REQ;
            end
         end

         ST_REQ: begin
            intr_d = 1'b1;
            if (Inta) begin
               ack     = 1'b1;
               intr_d  = 1'b0;
               state_d = ST_SERVICE;
            end
         end

         ST_SERVICE: begin
            intr_d = 1'b0;
            if (Eoi) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            intr_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Pending and mask registers
   // ---------------------------------------------------------------------------
   always_comb begin
      pending_d = pending_q;
      // Clear the acknowledged source first so a coincident rise on the same
      // bit re-posts it (set wins).
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (ack && (cause_q == CAUSE_W'(i))) begin
            pending_d[i] = 1'b0;
         end
      end
      pending_d = pending_d | rise;

      // Mask writes never touch Pending; masked sources simply wait.
      mask_d = MaskWe ? MaskWdata : mask_q;
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (Reset) begin
         state_q   <= ST_IDLE;
         history_q <= '0;
         pending_q <= '0;
         mask_q    <= '1;
         intr_q    <= 1'b0;
         cause_q   <= '0;
      end else begin
         state_q   <= state_d;
         history_q <= history_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         intr_q    <= intr_d;
         cause_q   <= cause_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign Intr    = intr_q;
   assign Cause   = cause_q;
   assign Pending = pending_q;
   assign Mask    = mask_q;

endmodule : intr_controller

// File: tb/tb_intr_controller.sv
// -----------------------------------------------------------------------------
// tb_intr_controller
// Self-checking bench for intr_controller. A behavioural reference model
// advances on every rising clock edge from the applied inputs; whenever it
// decides a new request is presented it pushes the expected cause into a
// scoreboard queue. A monitor on the falling edge pops one entry per observed
// rising Intr and also compares Intr/Cause/Pending/Mask against the model.
// Directed scenarios come first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_intr_controller;

   localparam int N = 4;
   localparam int CW = 2;

   logic          Clk;
   logic          Reset;
   logic [N-1:0]  Irq;
   logic          MaskWe;
   logic [N-1:0]  MaskWdata;
   logic          Inta;
   logic          Eoi;
   logic          Intr;
   logic [CW-1:0] Cause;
   logic [N-1:0]  Pending;
   logic [N-1:0]  Mask;

   intr_controller #(
      .N_SRC   (N),
      .CAUSE_W (CW)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Irq       (Irq),
      .MaskWe    (MaskWe),
      .MaskWdata (MaskWdata),
      .Inta      (Inta),
      .Eoi       (Eoi),
      .Intr      (Intr),
      .Cause     (Cause),
      .Pending   (Pending),
      .Mask      (Mask)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------------------------------------------------------------------
   // Counters and check task
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: sets of pending/enabled sources and a handshake phase
   //   phase 0 = nothing presented, 1 = awaiting acknowledge, 2 = in service
   // ---------------------------------------------------------------------------
   bit         model_valid = 0;
   int         m_phase;
   int         m_cause;
   bit [N-1:0] m_prev;
   bit [N-1:0] m_pend;
   bit [N-1:0] m_mask;
   int         exp_q[$];

   always @(posedge Clk) begin
      if (Reset) begin
         m_phase     = 0;
         m_cause     = 0;
         m_prev      = '0;
         m_pend      = '0;
         m_mask      = '1;
         model_valid = 1;
      end else if (model_valid) begin
         if (m_phase == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
               if (m_pend[i] && m_mask[i]) m_cause = i;
            end
            if ((m_pend & m_mask) != 0) begin
               m_phase = 1;
               exp_q.push_back(m_cause);
            end
         end else if (m_phase == 1 && Inta) begin
            m_pend[m_cause] = 1'b0;
            m_phase = 2;
         end else if (m_phase == 2 && Eoi) begin
            m_phase = 0;
         end
         // New rising edges are posted after any acknowledge clear.
         for (int i = 0; i < N; i++) begin
            if (Irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
         end
         if (MaskWe) m_mask = MaskWdata;
         m_prev = Irq;
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor: cycle compare plus scoreboard pop on each new request
   // ---------------------------------------------------------------------------
   logic intr_seen = 1'b0;

   always @(negedge Clk) begin
      if (model_valid) begin
         check("intr",    32'(Intr),    32'(m_phase == 1));
         check("cause",   32'(Cause),   32'(m_cause));
         check("pending", 32'(Pending), 32'(m_pend));
         check("mask",    32'(Mask),    32'(m_mask));
         if (Intr && !intr_seen) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_cause: got request cause %0d expected no request at %0t", Cause, $time);
            end else begin
               check("sb_cause", 32'(Cause), 32'(exp_q.pop_front()));
            end
         end
         intr_seen = Intr;
      end
   end

   // Safety net: the run is bounded by fixed loops, but never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic pulse_inta();
      Inta = 1'b1;
      step(1);
      Inta = 1'b0;
   endtask

   task automatic pulse_eoi();
      Eoi = 1'b1;
      step(1);
      Eoi = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Irq = '0; MaskWe = 1'b0; MaskWdata = '0; Inta = 1'b0; Eoi = 1'b0;

      // Reset values
      step(2);
      Reset = 1'b0;
      check("rst_intr",    32'(Intr),    32'd0);
      check("rst_cause",   32'(Cause),   32'd0);
      check("rst_pending", 32'(Pending), 32'h0);
      check("rst_mask",    32'(Mask),    32'hf);
      step(1);

      // Single request on line 2
      Irq = 4'b0100;
      step(2);
      check("single_intr",  32'(Intr),  32'd1);
      check("single_cause", 32'(Cause), 32'd2);
      pulse_inta();
      check("single_ack_intr",    32'(Intr),    32'd0);
      check("single_ack_pending", 32'(Pending), 32'h0);
      pulse_eoi();
      step(1);
      check("single_eoi_intr", 32'(Intr), 32'd0);
      Irq = '0;
      step(1);

      // Simultaneous requests on lines 1 and 3
      Irq = 4'b1010;
      step(2);
      check("simul_cause1", 32'(Cause), 32'd1);
      pulse_inta();
      pulse_eoi();
      step(1);
      check("simul_intr2",  32'(Intr),  32'd1);
      check("simul_cause3", 32'(Cause), 32'd3);
      pulse_inta();
      pulse_eoi();
      Irq = '0;
      step(1);

      // Masked source stays pending until enabled
      MaskWe = 1'b1; MaskWdata = 4'b1011;
      step(1);
      MaskWe = 1'b0;
      Irq = 4'b0100;
      step(10);
      check("mask_pending", 32'(Pending), 32'h4);
      check("mask_intr",    32'(Intr),    32'd0);
      MaskWe = 1'b1; MaskWdata = 4'b1111;
      step(1);
      MaskWe = 1'b0;
      step(1);
      check("unmask_intr",  32'(Intr),  32'd1);
      check("unmask_cause", 32'(Cause), 32'd2);
      pulse_inta();
      pulse_eoi();
      Irq = '0;
      step(1);

      // Re-arm during service
      Irq = 4'b0001;
      step(2);
      check("rearm_cause", 32'(Cause), 32'd0);
      pulse_inta();
      Irq = 4'b0000;
      step(1);
      Irq = 4'b0001;
      step(1);
      check("rearm_pending", 32'(Pending), 32'h1);
      check("rearm_intr",    32'(Intr),    32'd0);
      step(3);
      check("rearm_hold_intr", 32'(Intr), 32'd0);
      pulse_eoi();
      step(1);
      check("rearm_reassert", 32'(Intr), 32'd1);
      pulse_inta();
      pulse_eoi();
      step(5);
      check("held_no_repost_pending", 32'(Pending), 32'h0);
      check("held_no_repost_intr",    32'(Intr),    32'd0);

      // Reset mid-operation
      Irq = '0;
      step(1);
      Irq = 4'b0101;
      step(2);
      check("midrst_pre_pending", 32'(Pending), 32'h5);
      check("midrst_pre_intr",    32'(Intr),    32'd1);
      Reset = 1'b1; Irq = '0;
      step(1);
      check("midrst_intr",    32'(Intr),    32'd0);
      check("midrst_pending", 32'(Pending), 32'h0);
      Reset = 1'b0;
      pulse_inta();
      check("stray_inta_intr",    32'(Intr),    32'd0);
      check("stray_inta_pending", 32'(Pending), 32'h0);

      // Randomized traffic, including stray Inta/Eoi and occasional reset
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] tog;
         for (int i = 0; i < N; i++) tog[i] = ($urandom_range(7) == 0);
         Irq       = Irq ^ tog;
         MaskWe    = ($urandom_range(31) == 0);
         MaskWdata = N'($urandom);
         Inta      = Intr ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
         Eoi       = ($urandom_range(3) == 0);
         Reset     = ($urandom_range(499) == 0);
         step(1);
      end
      Reset = 1'b0; MaskWe = 1'b0; Inta = 1'b0; Eoi = 1'b0;
      step(3);

      check("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_intr_controller

// File: doc/intr_controller.md
# intr_controller

Interrupt controller for the single-cycle CPU. It collects edge-triggered requests from up to `N_SRC` peripheral lines and masks them. It presents one request at a time to the CPU's `Intr` input, with a fixed-priority cause index. It completes the handshake with the CPU's `Inta` acknowledge, and holds off further requests until the handler signals end-of-interrupt. It is the requesting end of the `Intr`/`Inta` pair that the CPU core responds to.

## Interface
Parameters:
- `N_SRC`, default 4: number of interrupt source lines.
- `CAUSE_W`, default 2: width of the cause index; must equal clog2(`N_SRC`).

Ports:
- `Clk`, in, 1: the only clock; all state updates on its rising edge.
- `Reset`, in, 1: reset, synchronous and active-high.
- `Irq`, in, `N_SRC`: peripheral request lines; a rising edge (low on one sampling edge, high on the next) posts a request.
- `MaskWe`, in, 1: write strobe for the enable mask.
- `MaskWdata`, in, `N_SRC`: new mask value; bit = 1 means the source is enabled.
- `Inta`, in, 1: CPU acknowledge, one-cycle pulse.
- `Eoi`, in, 1: end-of-interrupt pulse from the handler return.
- `Intr`, out, 1: interrupt request to the CPU; registered.
- `Cause`, out, `CAUSE_W`: index of the requested/in-service source; registered.
- `Pending`, out, `N_SRC`: pending-request status.
- `Mask`, out, `N_SRC`: current enable mask.

## Operation
- **Reset values:**
  - `Intr`=0, `Cause`=0, `Pending`=0, `Mask`=all ones.
  - Edge-detect history register = 0; state = IDLE.
- **Edge detect:**
  - rise[i] = `Irq`[i] & ~history[i]; history <= `Irq` every cycle.
  - A line already high when reset releases counts as a rise on the first cycle.
  - A line held high posts only one request.
- **Pending:** `Pending`[i] is set on rise[i] and cleared on acknowledge of source i. If set and clear coincide on the same bit, set wins.
- **Mask:** on `MaskWe`, `Mask` <= `MaskWdata`. Masking never clears `Pending`.
- **Priority:** the lowest index among `Pending` & `Mask` wins.
- **State machine:**
  - IDLE: if (`Pending` & `Mask`) != 0, latch `Cause` <= winner and go to REQ.
  - REQ: `Intr`=1 and `Cause` is frozen. A later higher-priority arrival or a mask change does not alter `Cause` or withdraw `Intr`. On `Inta`: clear `Pending`[`Cause`] and go to SERVICE.
  - SERVICE: `Intr`=0 and `Cause` is held. On `Eoi`, go to IDLE.
- **Ignored inputs:** `Inta` outside REQ; `Eoi` outside SERVICE.
- **No nesting:** new requests only accumulate in `Pending` during REQ/SERVICE.

## Timing
- Request latency: rise sampled at edge k → `Pending` bit set after k → `Intr`=1 and `Cause` valid after edge k+1.
- Acknowledge: `Inta` sampled at edge m → `Intr`=0 and `Pending`[`Cause`]=0 after edge m.
- Re-request: `Eoi` at edge p → IDLE after p. If enabled requests remain pending, `Intr`=1 again after edge p+1.
- Unmask: `MaskWe` at edge k enabling a pending source (in IDLE) → `Intr`=1 after edge k+1.
- Reset mid-operation: state returns to IDLE at the reset edge and all reset values apply. Any in-flight handshake is dropped.

## Structure
- Package `intr_pkg` holds:
  - the state enum (IDLE, REQ, SERVICE);
  - default `N_SRC` and `CAUSE_W` constants.
- One sub-module, `intr_prio_enc`: combinational lowest-index-first encoder from `N_SRC` request bits to a `CAUSE_W` index plus a valid flag.
- Edge detect, pending/mask registers and the FSM stay in the top.

## Test plan
- **Reset:** hold `Reset`=1 for 2 cycles, then release with `Irq`=0 → `Intr`=0, `Cause`=0, `Pending`=4'b0000, `Mask`=4'b1111.
- **Single request:**
  - `Irq`[2] rises at edge k → `Intr`=1, `Cause`=2 after k+1.
  - `Inta` at m → `Intr`=0 and `Pending`=0 after m.
  - `Eoi` → state back to IDLE, `Intr` stays 0.
- **Simultaneous requests:**
  - `Irq`[1] and `Irq`[3] rise on the same edge → `Cause`=1 first.
  - `Inta`, then `Eoi` at p → `Intr`=1 with `Cause`=3 after p+1.
- **Masking:**
  - Write `Mask`=4'b1011, then raise `Irq`[2] → `Pending`=4'b0100, `Intr` stays 0 for 10 cycles.
  - Write `Mask`=4'b1111 at edge k → `Intr`=1, `Cause`=2 after k+1.
- **Re-arm during service:**
  - In SERVICE for source 0, `Irq`[0] falls and rises again → `Pending`[0]=1 and `Intr` stays 0 until `Eoi`, then reasserts.
  - A line held high across the whole sequence posts no second request.
- **Reset mid-operation:** assert `Reset` while in REQ with `Pending`=4'b0101 → `Intr`=0 and `Pending`=0 after that edge. A stray `Inta` afterwards has no effect.
